ring_arbiter: RTL and testbench

RING_ARBITER -- requirements
Module: ring_arbiter

---
 rtl/ring_arbiter_if.sv | 25 ++
 rtl/ring_arbiter.sv | 122 ++++++++++++
 tb/tb_ring_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_arbiter_if.sv
// Ring arbiter bus: per-port request/tail inputs, downstream ready,
// and the registered grant / status outputs of the arbiter.
interface ring_arbiter_if;
    logic [2:0] req;          // bit0 local, bit1 clockwise, bit2 counter-clockwise
    logic [2:0] tail;         // last flit of the packet, valid with req of the same bit
    logic       out_ready;    // downstream ring link can take a flit this cycle
    logic       g00;          // one-hot grant, port 0
    logic       g01;          // one-hot grant, port 1
    logic       g02;          // one-hot grant, port 2
    logic       xfer;         // a flit moves this cycle
    logic       busy;         // arbiter holds a grant
    logic       timeout_err;  // one-cycle pulse on watchdog release

    // Requesting side: drives requests and downstream ready, observes grants.
    modport master (
        output req, tail, out_ready,
        input  g00, g01, g02, xfer, busy, timeout_err
    );

    // Arbiter side.
    modport slave (
        input  req, tail, out_ready,
        output g00, g01, g02, xfer, busy, timeout_err
    );
endinterface

// File: rtl/ring_arbiter.sv
// Three-port round-robin packet arbiter for a ring stop.
// A grant is held from the first flit to the tail flit; a watchdog drops a
// grant that stalls for more than LOCK_MAX consecutive cycles.
module ring_arbiter #(
    parameter int LOCK_MAX = 15,   // stall cycles tolerated before forced release
    parameter int CNT_W    = 4     // watchdog width, 2**CNT_W must exceed LOCK_MAX
) (
    input  logic          clk,
    input  logic          rst,     // asynchronous, active low
    ring_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;       // port searched first on the next arbitration
    logic [2:0]       r_gnt;       // one-hot grant, all-zero in IDLE
    logic [CNT_W-1:0] r_wdog;      // consecutive stall cycles of the current grant
    logic             r_timeout;

    logic [1:0]       w_ptr;       // pointer with the unreachable value 3 folded to 0
    logic [1:0]       w_cand0;
    logic [1:0]       w_cand1;
    logic [1:0]       w_cand2;
    logic             w_win_vld;
    logic [1:0]       w_win_idx;
    logic [1:0]       w_gnt_idx;
    logic [1:0]       w_ptr_next;
    logic             w_req_g;
    logic             w_tail_g;
    logic             w_xfer;
    logic             w_wdog_max;

    // Next port around the ring, modulo 3.
    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_ptr   = (r_ptr == 2'd3) ? 2'd0 : r_ptr;
    assign w_cand0 = w_ptr;
    assign w_cand1 = inc3(w_cand0);
    assign w_cand2 = inc3(w_cand1);

    // Round-robin search: first requesting port in order ptr, ptr+1, ptr+2.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missed branch infers a latch.
        w_win_vld = 1'b1;
        w_win_idx = w_cand0;
        if (bus.req[w_cand0])      w_win_idx = w_cand0;
        else if (bus.req[w_cand1]) w_win_idx = w_cand1;
        else if (bus.req[w_cand2]) w_win_idx = w_cand2;
        else                       w_win_vld = 1'b0;
    end

    // Only the granted port's request and tail matter while a grant is held.
    assign w_req_g    = |(bus.req  & r_gnt);
    assign w_tail_g   = |(bus.tail & r_gnt);
    assign w_gnt_idx  = r_gnt[2] ? 2'd2 : (r_gnt[1] ? 2'd1 : 2'd0);
    assign w_ptr_next = inc3(w_gnt_idx);
    assign w_xfer     = (r_state == GRANT) && w_req_g && bus.out_ready;
    assign w_wdog_max = (r_wdog == CNT_W'(LOCK_MAX));

    // Arbitration FSM: grant, hold across the packet, release on tail or watchdog.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset clears the grant without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_gnt     <= 3'b000;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.out_ready && w_win_vld) begin
                        r_state <= GRANT;
                        r_gnt   <= 3'b001 << w_win_idx;
                        r_wdog  <= '0;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        // A moving flit beats the watchdog, even at LOCK_MAX.
                        r_wdog <= '0;
                        if (w_tail_g) begin
                            r_state <= IDLE;
                            r_gnt   <= 3'b000;
                            r_ptr   <= w_ptr_next;
                        end
                    end else if (w_wdog_max) begin
                        r_state   <= IDLE;
                        r_gnt     <= 3'b000;
                        r_ptr     <= w_ptr_next;
                        r_wdog    <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 3'b000;
                    r_wdog  <= '0;
                end
            endcase
        end
    end

    assign bus.g00         = r_gnt[0];
    assign bus.g01         = r_gnt[1];
    assign bus.g02         = r_gnt[2];
    assign bus.xfer        = w_xfer;
    assign bus.busy        = (r_state == GRANT);
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_ring_arbiter.sv
// Self-checking bench for ring_arbiter: a cycle model predicts grants,
// busy and timeout for every driven cycle; predictions go through a
// scoreboard queue and are compared after the clock edge.
module tb_ring_arbiter;
    localparam int LOCK_MAX = 15;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic rst;

    ring_arbiter_if bus();

    ring_arbiter #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] gnt;
        logic       busy;
        logic       tout;
    } exp_t;

    exp_t sb_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int n_xfer  = 0;
    int n_tout  = 0;
    bit mon_en  = 1'b0;

    // Reference model state
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_wd;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] dut_gnt();
        return {bus.g02, bus.g01, bus.g00};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_ptr  = 0;
        m_wd   = 0;
    endtask

    // One clock cycle: drive inputs, check xfer, predict, compare after the edge.
    task automatic step(input logic [2:0] r, input logic [2:0] t, input logic rdy);
        exp_t e;
        bit   mx;
        bit   tout;
        bus.req       = r;
        bus.tail      = t;
        bus.out_ready = rdy;
        #1;
        mx = m_busy && r[m_g] && rdy;
        check("xfer", 8'(bus.xfer), 8'(mx));
        if (mx) n_xfer++;
        tout = 1'b0;
        if (!m_busy) begin
            if (rdy && r != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    int p = (m_ptr + k) % 3;
                    if (r[p]) begin
                        m_g    = p;
                        m_busy = 1'b1;
                        m_wd   = 0;
                        break;
                    end
                end
            end
        end else if (mx) begin
            m_wd = 0;
            if (t[m_g]) begin
                m_busy = 1'b0;
                m_ptr  = (m_g + 1) % 3;
            end
        end else if (m_wd == LOCK_MAX) begin
            m_busy = 1'b0;
            tout   = 1'b1;
            m_ptr  = (m_g + 1) % 3;
            m_wd   = 0;
        end else begin
            m_wd++;
        end
        e.gnt  = m_busy ? 3'(1 << m_g) : 3'b000;
        e.busy = m_busy;
        e.tout = tout;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("gnt",  8'(dut_gnt()),       8'(e.gnt));
        check("busy", 8'(bus.busy),        8'(e.busy));
        check("tout", 8'(bus.timeout_err), 8'(e.tout));
        if (bus.timeout_err) n_tout++;
    endtask

    // Invariants sampled on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot0", 8'($onehot0(dut_gnt())), 8'h01);
            if (!bus.busy) begin
                check("idle_gnt",  8'(dut_gnt()), 8'h00);
                check("idle_xfer", 8'(bus.xfer),  8'h00);
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.req       = 3'b000;
        bus.tail      = 3'b000;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_gnt",  8'(dut_gnt()),       8'h00);
        check("rst_busy", 8'(bus.busy),        8'h00);
        check("rst_tout", 8'(bus.timeout_err), 8'h00);
        check("rst_xfer", 8'(bus.xfer),        8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Fairness rotation with all ports requesting
        step(3'b111, 3'b000, 1'b1);
        check("rot_g00a", 8'(dut_gnt()), 8'h01);
        step(3'b111, 3'b001, 1'b1);
        step(3'b111, 3'b000, 1'b1);
        check("rot_g01", 8'(dut_gnt()), 8'h02);
        step(3'b111, 3'b010, 1'b1);
        step(3'b111, 3'b000, 1'b1);
        check("rot_g02", 8'(dut_gnt()), 8'h04);
        step(3'b111, 3'b100, 1'b1);
        step(3'b111, 3'b000, 1'b1);
        check("rot_g00b", 8'(dut_gnt()), 8'h01);
        step(3'b111, 3'b001, 1'b1);

        // Four-flit packet on port 2 with a ready bubble
        n_xfer = 0;
        step(3'b100, 3'b000, 1'b1);
        check("pkt_g02", 8'(dut_gnt()), 8'h04);
        step(3'b100, 3'b000, 1'b1);
        step(3'b100, 3'b000, 1'b0);
        check("pkt_hold", 8'(dut_gnt()), 8'h04);
        step(3'b100, 3'b000, 1'b1);
        step(3'b100, 3'b000, 1'b1);
        step(3'b100, 3'b100, 1'b1);
        check("pkt_nxfer", 8'(n_xfer), 8'd4);
        check("pkt_rel",   8'(dut_gnt()), 8'h00);
        step(3'b111, 3'b000, 1'b1);
        check("pkt_ptr0", 8'(dut_gnt()), 8'h01);
        step(3'b111, 3'b001, 1'b1);

        // Watchdog release on port 1; port 2 request ignored while granted
        n_tout = 0;
        step(3'b010, 3'b000, 1'b1);
        check("wd_g01", 8'(dut_gnt()), 8'h02);
        for (int i = 0; i < LOCK_MAX; i++) step(3'b100, 3'b100, 1'b1);
        check("wd_early", 8'(bus.timeout_err), 8'h00);
        check("wd_held",  8'(dut_gnt()),       8'h02);
        step(3'b100, 3'b100, 1'b1);
        check("wd_tout", 8'(bus.timeout_err), 8'h01);
        check("wd_drop", 8'(dut_gnt()),       8'h00);
        step(3'b100, 3'b000, 1'b1);
        check("wd_next_g02", 8'(dut_gnt()), 8'h04);
        check("wd_pulses",   8'(n_tout),    8'd1);
        step(3'b100, 3'b100, 1'b1);

        // Transfer with tail exactly when the watchdog sits at LOCK_MAX
        step(3'b001, 3'b000, 1'b1);
        check("wdx_g00", 8'(dut_gnt()), 8'h01);
        for (int i = 0; i < LOCK_MAX; i++) step(3'b001, 3'b000, 1'b0);
        step(3'b001, 3'b001, 1'b1);
        check("wdx_tout", 8'(bus.timeout_err), 8'h00);
        check("wdx_rel",  8'(dut_gnt()),       8'h00);
        check("wdx_cnt",  8'(n_tout),          8'd1);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while port 1 holds a grant
        for (int i = 0; i < 40; i++) begin
            if (bus.g01) break;
            step(3'b010, 3'b000, 1'b1);
        end
        check("wait_g01", 8'(bus.g01), 8'h01);
        #3;
        rst = 1'b0;
        #1;
        check("arst_g01",  8'(bus.g01),  8'h00);
        check("arst_busy", 8'(bus.busy), 8'h00);
        check("arst_xfer", 8'(bus.xfer), 8'h00);
        @(posedge clk);
        #1;
        check("arst_hold", 8'(dut_gnt()), 8'h00);
        #2;
        rst = 1'b1;
        model_reset();
        step(3'b010, 3'b000, 1'b1);
        check("arst_regrant", 8'(dut_gnt()), 8'h02);
        step(3'b010, 3'b010, 1'b1);

        // Pointer restarts at port 0 after reset
        #3;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        step(3'b111, 3'b000, 1'b1);
        check("arst_ptr0", 8'(dut_gnt()), 8'h01);
        step(3'b111, 3'b001, 1'b1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
